// File: rtl/bcd4_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One result bit per clock; start/busy/done handshake; digit validity check.
module bcd4_to_bin_seq #(
  parameter int NDIG  = 4,
  parameter int BIN_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*NDIG-1:0]  bcd_in,
  output logic [BIN_W-1:0]   bin_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int SW    = 4 * NDIG;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, ERRDONE} state_t;

  state_t             state;
  logic [SW-1:0]      s_reg;
  logic [BIN_W-1:0]   b_reg;
  logic [CNT_W-1:0]   cnt;

  logic               bad_digit;
  logic [SW-1:0]      s_shift;
  logic [SW-1:0]      s_corr;
  logic [BIN_W-1:0]   b_shift;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // A shifted digit of 8 or more held a "10" worth of weight; removing 3 restores base 10.
  always_comb begin
    s_shift = {1'b0, s_reg[SW-1:1]};
    b_shift = {s_reg[0], b_reg[BIN_W-1:1]};
    s_corr  = s_shift;
    for (int i = 0; i < NDIG; i++) begin
      if (s_shift[4*i+3]) s_corr[4*i +: 4] = s_shift[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (bad_digit) begin
              state <= ERRDONE;
            end else begin
              s_reg <= bcd_in;
              b_reg <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end
        CONV: begin
          s_reg <= s_corr;
          b_reg <= b_shift;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            bin_out <= b_shift;
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        ERRDONE: begin
          bin_out <= '0;
          err     <= 1'b1;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
